// File: rtl/adder_share_arb.sv
// adder_share_arb: one ripple-carry adder shared by NREQ requesters
// under round-robin arbitration, with registered sum/carry and winner id.
module adder_share_arb #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] a_in,
  input  logic [NREQ*N-1:0] b_in,
  input  logic [NREQ-1:0]   cin_in,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic [N-1:0]      sum,
  output logic              cout
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] w_q;
  logic [IDW-1:0] win;
  logic           win_vld;
  int             idx;

  logic [N-1:0]   a_w;
  logic [N-1:0]   b_w;
  logic           c_w;

  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic           op_c;

  logic [N:0]     carry;
  logic [N-1:0]   add_s;

  // Round-robin pick: first set req bit scanning upward from ptr, wrapping.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ)
        idx = idx - NREQ;
      for (int k = 0; k < NREQ; k++) begin
        if (!win_vld && k == idx && req[k]) begin
          win_vld = 1'b1;
          win     = IDW'(k);
        end
      end
    end
  end

  // Route the winner's operand slice toward the capture registers.
  always_comb begin
    a_w = '0;
    b_w = '0;
    c_w = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == IDW'(k)) begin
        a_w = a_in[k*N +: N];
        b_w = b_in[k*N +: N];
        c_w = cin_in[k];
      end
    end
  end

  assign carry[0] = op_c;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign add_s[i]   = op_a[i] ^ op_b[i] ^ carry[i];
    assign carry[i+1] = (op_a[i] & op_b[i])
                      | (carry[i] & (op_a[i] ^ op_b[i]));
  end

  // Control FSM: grant/capture in IDLE, add in EXEC, done pulse in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      w_q     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_c    <= 1'b0;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          gnt  <= '0;
          busy <= 1'b0;
          done <= 1'b0;
          if (win_vld) begin
            op_a  <= a_w;
            op_b  <= b_w;
            op_c  <= c_w;
            w_q   <= win;
            gnt   <= NREQ'(1) << win;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          sum     <= add_s;
          cout    <= carry[N];
          done    <= 1'b1;
          done_id <= w_q;
          gnt     <= '0;
          if (int'(w_q) == NREQ - 1)
            ptr <= '0;
          else
            ptr <= w_q + 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed stimulus, op-level reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_adder_share_arb;

  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic [NREQ-1:0]   req    = '0;
  logic [NREQ*N-1:0] a_in   = '0;
  logic [NREQ*N-1:0] b_in   = '0;
  logic [NREQ-1:0]   cin_in = '0;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              done;
  logic [IDW-1:0]    done_id;
  logic [N-1:0]      sum;
  logic              cout;

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  adder_share_arb #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .gnt(gnt), .busy(busy), .done(done),
    .done_id(done_id), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an op's life is "granted" (age 1) then "done" (age 2).
  int           m_age = 0;
  int           m_ptr = 0;
  int           m_w   = 0;
  int           m_res = 0;
  logic [N-1:0] e_sum = '0;
  logic         e_cout = 1'b0;
  int           e_id  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age  <= 0;
      m_ptr  <= 0;
      m_w    <= 0;
      m_res  <= 0;
      e_sum  <= '0;
      e_cout <= 1'b0;
      e_id   <= 0;
    end else if (m_age == 0) begin
      if (req != 0) begin : pick
        int k;
        int s;
        bit f;
        f = 1'b0;
        k = 0;
        for (int i = 0; i < NREQ; i++) begin
          if (!f && req[(m_ptr + i) % NREQ]) begin
            f = 1'b1;
            k = (m_ptr + i) % NREQ;
          end
        end
        s = int'(a_in[k*N +: N]) + int'(b_in[k*N +: N]) + int'(cin_in[k]);
        m_w   <= k;
        m_res <= s;
        m_age <= 1;
      end
    end else if (m_age == 1) begin
      e_sum  <= N'(m_res % (1 << N));
      e_cout <= (m_res >= (1 << N));
      e_id   <= m_w;
      m_ptr  <= (m_w + 1) % NREQ;
      m_age  <= 2;
    end else begin
      m_age <= 0;
    end
  end

  // Per-cycle comparison against the model, plus output invariants.
  always @(negedge clk) begin
    if (run) begin
      chk("gnt", gnt, (m_age == 1) ? (1 << m_w) : 0);
      chk("busy", busy, m_age != 0);
      chk("done", done, m_age == 2);
      chk("done_id", done_id, e_id);
      chk("sum", sum, e_sum);
      chk("cout", cout, e_cout);
      chk("gnt_onehot0", $onehot0(gnt), 1);
      chk("gnt_done_excl", (gnt != 0) && done, 0);
    end
  end

  task automatic set_op(int k, logic [N-1:0] a, logic [N-1:0] b, logic c);
    a_in[k*N +: N] = a;
    b_in[k*N +: N] = b;
    cin_in[k]      = c;
  endtask

  task automatic wait_gnt(output int id);
    int t;
    id = -1;
    t  = 0;
    while (id < 0 && t < 12) begin
      @(negedge clk);
      t++;
      for (int k = 0; k < NREQ; k++)
        if (gnt[k]) id = k;
    end
    if (id < 0)
      chk("gnt_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    run = 1'b1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
  endtask

  // Single-requester op; operands are scrambled once the grant is seen.
  task automatic op(int k, logic [N-1:0] a, logic [N-1:0] b, logic c,
                    logic [N-1:0] es, logic ec);
    int id;
    set_op(k, a, b, c);
    req = NREQ'(1) << k;
    wait_gnt(id);
    chk("op_gnt_id", id, k);
    req = '0;
    set_op(k, ~a, ~b, ~c);
    @(negedge clk);
    chk("op_done", done, 1);
    chk("op_done_id", done_id, k);
    chk("op_sum", sum, es);
    chk("op_cout", cout, ec);
    @(negedge clk);
    chk("op_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    int id;
    int n;
    int ids[5];
    int tms[5];
    int exp_ids[5];

    exp_ids = '{0, 1, 2, 3, 0};

    do_reset();
    op(0, 4'h3, 4'h5, 1'b0, 4'h8, 1'b0);
    op(2, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
    op(2, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1);

    // Contention: all four requesting from reset.
    @(negedge clk);
    rst_n = 1'b0;
    set_op(0, 4'h3, 4'h9, 1'b0);
    set_op(1, 4'h7, 4'h9, 1'b1);
    set_op(2, 4'hC, 4'h2, 1'b1);
    set_op(3, 4'h5, 4'hB, 1'b0);
    req = 4'b1111;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int t = 1; t <= 40 && n < 5; t++) begin
      @(negedge clk);
      if (gnt != 0) begin
        for (int k = 0; k < NREQ; k++)
          if (gnt[k]) ids[n] = k;
        tms[n] = t;
        n++;
      end
    end
    chk("cont_count", n, 5);
    chk("cont_first_t", tms[0], 1);
    for (int i = 0; i < 5; i++) begin
      if (i < n) begin
        chk("cont_order", ids[i], exp_ids[i]);
        if (i > 0)
          chk("cont_spacing", tms[i] - tms[i-1], 3);
      end
    end
    req = '0;
    repeat (2) @(negedge clk);
    chk("cont_idle", busy, 0);

    // Rotation skip: ptr=1 after serving 0; req=1001 picks 3 first.
    do_reset();
    op(0, 4'h1, 4'h2, 1'b0, 4'h3, 1'b0);
    set_op(3, 4'h7, 4'h9, 1'b1);
    set_op(0, 4'h4, 4'h4, 1'b0);
    req = 4'b1001;
    wait_gnt(id);
    chk("rot_first", id, 3);
    req = 4'b0001;
    @(negedge clk);
    chk("rot_id3", done_id, 3);
    chk("rot_sum3", sum, 4'h1);
    chk("rot_cout3", cout, 1);
    wait_gnt(id);
    chk("rot_second", id, 0);
    req = '0;
    @(negedge clk);
    chk("rot_id0", done_id, 0);
    chk("rot_sum0", sum, 4'h8);
    @(negedge clk);

    // Async reset mid-EXEC discards the op.
    do_reset();
    op(3, 4'h2, 4'h3, 1'b0, 4'h5, 1'b0);
    set_op(1, 4'h6, 4'h7, 1'b0);
    req = 4'b0010;
    wait_gnt(id);
    chk("ar_gnt", id, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt_clr", gnt, 0);
    chk("ar_busy_clr", busy, 0);
    chk("ar_done_clr", done, 0);
    chk("ar_sum_clr", sum, 0);
    req = 4'b0100;
    set_op(2, 4'h4, 4'h9, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(id);
    chk("ar_first", id, 2);
    req = '0;
    @(negedge clk);
    chk("ar_done", done, 1);
    chk("ar_done_id", done_id, 2);
    chk("ar_sum", sum, 4'hD);
    chk("ar_cout", cout, 0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
